ifft_8pt_seq: RTL and testbench
===============================

IFFT_8PT_SEQ -- requirements
Module: ifft_8pt_seq

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit two's-complement.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  input bin present.
REQ-006 in_ready  out  1  block can accept a bin.
REQ-007 in_real  in  32  signed real part of bin X[k]; k implied by beat order 0..7.
REQ-008 in_img  in  32  signed imaginary part of bin X[k].
REQ-009 out_valid  out  1  time sample present.
REQ-010 out_ready  in  1  downstream accepts sample.
REQ-011 out_real  out  32  signed real part of x[n].
REQ-012 out_img  out  32  signed imaginary part of x[n].
REQ-013 out_index  out  3  sample index n of current output beat.
REQ-014 out_last  out  1  high with out_valid on beat n=7.

Function
REQ-015 FSM states LOAD, S1, S2, S3, OUT; reset state LOAD.
REQ-016 LOAD: in_ready=1; a bin is accepted on an edge with in_valid&&in_ready, stored at index k, k increments; 8th accept moves to S1.
REQ-017 S1, S2, S3: one radix-2 stage each, one clock each, in_ready=0, out_valid=0; S3 moves to OUT.
REQ-018 Stage S1, k=0..3: a[k]=X[k]+X[k+4]; a[k+4]=(X[k]-X[k+4])*W^k, W=e^(+j*pi/4).
REQ-019 Stage S2, pairs (i,i+2) within each half: b[i]=a[i]+a[i+2]; b[i+2]=(a[i]-a[i+2])*(1 for even i, j for odd i).
REQ-020 Stage S3, pairs (i,i+1): c[i]=b[i]+b[i+1]; c[i+1]=b[i]-b[i+1].
REQ-021 Twiddles: W^0=1 exact; W^2=j exact (re'=-im, im'=re); W^1: re'=P(re-im), im'=P(re+im); W^3: re'=P(-re-im), im'=P(re-im).
REQ-022 P(v) = (v*23170) arithmetic-shifted right 15 (floor), low 32 bits kept; sum formed before multiply.
REQ-023 All adds/subtracts wrap modulo 2^32; no saturation; inputs with |re|,|im| < 2^27 never wrap.
REQ-024 Output x[n] = c[bitrev3(n)] arithmetic-shifted right 3 (floor), real and imag independently.
REQ-025 OUT: out_valid=1, beats n=0..7 in order; out_real/out_img/out_index/out_last stable while out_valid&&!out_ready.
REQ-026 Beat advances on edge with out_valid&&out_ready; beat 7 accepted returns to LOAD with k=0.
REQ-027 Latency: out_valid first high after the 4th rising edge following the edge accepting bin 7, with out_ready irrelevant until OUT.
REQ-028 No overlap: in_ready=0 from S1 through end of OUT; in_valid ignored there.
REQ-029 Back-to-back: in_ready=1 in the cycle after beat 7 is accepted.

Reset
REQ-030 rst asserted at any time, including mid-LOAD or mid-OUT: state LOAD, k=0, n=0, partial frame discarded.
REQ-031 Reset values: in_ready=1, out_valid=0, out_last=0, out_index=0, out_real=0, out_img=0.
REQ-032 First accept possible on first rising edge after rst deasserts.

Verification
REQ-033 X[0]=800+0j, others 0, out_ready=1 -> eight beats x[n]=100+0j, out_last only on n=7, latency per REQ-027.
REQ-034 X[4]=80+0j, others 0 -> x[n]=+10,-10,+10,... real, imag 0.
REQ-035 X[2]=16+0j, others 0 -> x = 2, 2j, -2, -2j, 2, 2j, -2, -2j.
REQ-036 X[1]=8000+0j, others 0 -> bit-exact match to golden model of REQ-018..024 (x[1]=707+707j).
REQ-037 out_ready toggled randomly over 200 random frames (|X|<2^27) -> outputs held stable when stalled, bit-exact to golden model, no lost or duplicated beats.
REQ-038 rst pulsed after 5 input beats, then a full X[0]=8 frame -> outputs all 1+0j; no residue from the aborted frame.

Source files
------------

// File: rtl/ifft_8pt_seq.sv
// 8-point sequential inverse FFT: loads 8 bins, runs three radix-2
// stages one clock each, then streams x[0..7] with a valid/ready handshake.
module ifft_8pt_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_real,
  input  logic signed [31:0] in_img,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_real,
  output logic signed [31:0] out_img,
  output logic [2:0]         out_index,
  output logic               out_last
);

  typedef enum logic [2:0] {LOAD, S1, S2, S3, OUT} state_t;

  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] n_q, n_d;
  logic signed [31:0] re_q [8];
  logic signed [31:0] im_q [8];
  logic signed [31:0] re_d [8];
  logic signed [31:0] im_d [8];
  logic ov_q, ov_d;
  logic last_q, last_d;
  logic signed [31:0] ore_q, ore_d;
  logic signed [31:0] oim_q, oim_d;

  // 23170/2^15 ~ 1/sqrt(2); floor shift, keep the low word.
  function automatic logic [31:0] p_mul(input logic [31:0] v);
    return 32'((64'($signed(v)) * 64'sd23170) >>> 15);
  endfunction

  // Multiply (re,im) by W^e, W = e^(+j*pi/4); returns {re', im'}.
  function automatic logic [63:0] rot(
    input logic [31:0] re,
    input logic [31:0] im,
    input logic [1:0]  e
  );
    logic [63:0] r;
    r = {re, im};
    unique case (e)
      2'd0: r = {re, im};
      2'd1: r = {p_mul(re - im), p_mul(re + im)};
      2'd2: r = {32'd0 - im, re};
      2'd3: r = {p_mul(32'd0 - re - im), p_mul(re - im)};
      default: r = {re, im};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] bitrev(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  logic signed [31:0] dr, di;
  logic [63:0] tw;
  logic [2:0] nn;
  logic ld;
  int p;

  // Next-state, butterfly stages and output beat selection.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    re_d     = re_q;
    im_d     = im_q;
    ov_d     = ov_q;
    last_d   = last_q;
    ore_d    = ore_q;
    oim_d    = oim_q;
    in_ready = 1'b0;
    nn       = n_q;
    ld       = 1'b0;
    dr       = '0;
    di       = '0;
    tw       = '0;
    p        = 0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          re_d[k_q] = in_real;
          im_d[k_q] = in_img;
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = S1;
        end
      end
      S1: begin
        for (int k = 0; k < 4; k++) begin
          re_d[k] = re_q[k] + re_q[k+4];
          im_d[k] = im_q[k] + im_q[k+4];
          dr = re_q[k] - re_q[k+4];
          di = im_q[k] - im_q[k+4];
          tw = rot(dr, di, 2'(k));
          re_d[k+4] = tw[63:32];
          im_d[k+4] = tw[31:0];
        end
        state_d = S2;
      end
      S2: begin
        for (int j = 0; j < 4; j++) begin
          p = (j / 2) * 4 + (j % 2);
          re_d[p] = re_q[p] + re_q[p+2];
          im_d[p] = im_q[p] + im_q[p+2];
          dr = re_q[p] - re_q[p+2];
          di = im_q[p] - im_q[p+2];
          tw = rot(dr, di, (j % 2 == 1) ? 2'd2 : 2'd0);
          re_d[p+2] = tw[63:32];
          im_d[p+2] = tw[31:0];
        end
        state_d = S3;
      end
      S3: begin
        for (int j = 0; j < 4; j++) begin
          re_d[2*j]   = re_q[2*j] + re_q[2*j+1];
          im_d[2*j]   = im_q[2*j] + im_q[2*j+1];
          re_d[2*j+1] = re_q[2*j] - re_q[2*j+1];
          im_d[2*j+1] = im_q[2*j] - im_q[2*j+1];
        end
        state_d = OUT;
      end
      OUT: begin
        if (!ov_q) begin
          ld   = 1'b1;
          ov_d = 1'b1;
        end else if (out_ready) begin
          if (n_q == 3'd7) begin
            ov_d    = 1'b0;
            last_d  = 1'b0;
            n_d     = 3'd0;
            k_d     = 3'd0;
            state_d = LOAD;
          end else begin
            nn  = n_q + 3'd1;
            ld  = 1'b1;
            n_d = nn;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (ld) begin
      ore_d  = re_q[bitrev(nn)] >>> 3;
      oim_d  = im_q[bitrev(nn)] >>> 3;
      last_d = (nn == 3'd7);
    end
  end

  // State, working memory and registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      k_q     <= '0;
      n_q     <= '0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      ore_q   <= '0;
      oim_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
      last_q  <= last_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign out_valid = ov_q;
  assign out_real  = ore_q;
  assign out_img   = oim_q;
  assign out_index = n_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_ifft_8pt_seq.sv
// Bench for ifft_8pt_seq: directed bin vectors, reset aborts,
// and random frames with random back-pressure against a reference model.
module tb_ifft_8pt_seq;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic signed [31:0] in_real, in_img;
  logic out_valid, out_ready;
  logic signed [31:0] out_real, out_img;
  logic [2:0] out_index;
  logic out_last;

  ifft_8pt_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_img(in_img),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_img(out_img),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xr [8];
  int xi [8];
  int er [8];
  int ei [8];

  typedef struct {
    int k;
    int re;
    int im;
    int er [8];
    int ei [8];
  } vec_t;

  vec_t vt [5];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pm(int v);
    longint t;
    t = longint'(v) * 64'sd23170;
    return int'(t >>> 15);
  endfunction

  // Reference: generic decimation-in-frequency loop over spans 4,2,1.
  task automatic model();
    int vr [8];
    int vi [8];
    for (int i = 0; i < 8; i++) begin
      vr[i] = xr[i];
      vi[i] = xi[i];
    end
    for (int h = 4; h >= 1; h = h / 2) begin
      for (int i = 0; i < 8; i++) begin
        if ((i & h) == 0) begin
          int ur, ui, wr, wi, e;
          ur = vr[i] - vr[i+h];
          ui = vi[i] - vi[i+h];
          vr[i] = vr[i] + vr[i+h];
          vi[i] = vi[i] + vi[i+h];
          e = (i % h) * (4 / h);
          case (e)
            1: begin wr = pm(ur - ui); wi = pm(ur + ui); end
            2: begin wr = -ui; wi = ur; end
            3: begin wr = pm(-ur - ui); wi = pm(ur - ui); end
            default: begin wr = ur; wi = ui; end
          endcase
          vr[i+h] = wr;
          vi[i+h] = wi;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      int b;
      b = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      er[n] = vr[b] >>> 3;
      ei[n] = vi[b] >>> 3;
    end
  endtask

  // Call at a negedge; leaves the bench at the negedge after the last accept.
  task automatic send_frame(int nb);
    for (int b = 0; b < nb; b++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_real = xr[b];
      in_img = xi[b];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic receive(bit rnd);
    int n = 0;
    int waits = 0;
    int guard = 0;
    bit seen = 1'b0;
    bit rdy;
    while (n < 8 && guard < 400) begin
      guard++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (!seen) chk("latency", waits, 4);
        seen = 1'b1;
        chk("out_index", out_index, n);
        chk("out_real", out_real, er[n]);
        chk("out_img", out_img, ei[n]);
        chk("out_last", out_last, n == 7);
        chk("in_ready_out", in_ready, 0);
        out_ready = rdy;
        in_valid = (rdy && n == 7) ? 1'b0 :
                   (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        in_real = $urandom;
        in_img = $urandom;
        if (rdy) n++;
      end else begin
        if (seen) chk("out_valid_gap", out_valid, 1);
        waits++;
        chk("in_ready_busy", in_ready, 0);
        out_ready = rdy;
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        in_real = $urandom;
        in_img = $urandom;
      end
      @(negedge clk);
    end
    chk("beats_received", n, 8);
    chk("b2b_in_ready", in_ready, 1);
    chk("out_valid_idle", out_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_real"}, out_real, 0);
    chk({tag, "_out_img"}, out_img, 0);
  endtask

  task automatic load_vec(int v);
    for (int i = 0; i < 8; i++) begin
      xr[i] = 0;
      xi[i] = 0;
      er[i] = vt[v].er[i];
      ei[i] = vt[v].ei[i];
    end
    xr[vt[v].k] = vt[v].re;
    xi[vt[v].k] = vt[v].im;
  endtask

  initial begin
    vt[0] = '{0, 800, 0,
              '{100, 100, 100, 100, 100, 100, 100, 100},
              '{0, 0, 0, 0, 0, 0, 0, 0}};
    vt[1] = '{4, 80, 0,
              '{10, -10, 10, -10, 10, -10, 10, -10},
              '{0, 0, 0, 0, 0, 0, 0, 0}};
    vt[2] = '{2, 16, 0,
              '{2, 0, -2, 0, 2, 0, -2, 0},
              '{0, 2, 0, -2, 0, 2, 0, -2}};
    vt[3] = '{1, 8000, 0,
              '{1000, 707, 0, -707, -1000, -707, 0, 707},
              '{0, 707, 1000, 707, 0, -707, -1000, -707}};
    vt[4] = '{0, -9, 17,
              '{-2, -2, -2, -2, -2, -2, -2, -2},
              '{2, 2, 2, 2, 2, 2, 2, 2}};

    rst = 1'b1;
    in_valid = 1'b0;
    in_real = '0;
    in_img = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      send_frame(8);
      receive(v % 2 == 1);
    end

    // Abort mid-load, then a clean frame must show no residue.
    for (int i = 0; i < 8; i++) begin
      xr[i] = 777;
      xi[i] = -555;
    end
    send_frame(5);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort_load");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xr[i] = 0;
      xi[i] = 0;
      er[i] = 1;
      ei[i] = 0;
    end
    xr[0] = 8;
    send_frame(8);
    receive(1'b0);

    // Abort mid-output, then a known frame.
    load_vec(0);
    send_frame(8);
    for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
    chk("pre_abort_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_abort_index", out_index, 2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort_out");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    load_vec(1);
    send_frame(8);
    receive(1'b0);

    // Random frames with random stalls and junk on the input side.
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 8; i++) begin
        xr[i] = int'($urandom_range(0, (1 << 28) - 2)) - ((1 << 27) - 1);
        xi[i] = int'($urandom_range(0, (1 << 28) - 2)) - ((1 << 27) - 1);
      end
      model();
      send_frame(8);
      receive(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
